// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: checks the period of clk_div_i in clk_i cycles and reports lock/errors.
// Optional high-time (duty) check is enabled by defining CLK_DIV_MON_DUTY_CHECK_EN.
//
// state   | meaning
// IDLE    | monitor disabled, counters cleared
// ACQUIRE | waiting for a first rise to align the period counter
// MEASURE | checking periods, counting consecutive good ones
// LOCKED  | LOCK_CNT consecutive good periods seen, lock_o high
module clk_div_monitor #(
    parameter int DIV_RATIO = 4,
    parameter int LOCK_CNT  = 4
) (
    input  logic       clk_i,
    input  logic       rst,
    input  logic       en,
    input  logic       clk_div_i,
    output logic       lock_o,
    output logic       err_o,
    output logic [7:0] period_o,
    output logic [7:0] err_cnt_o,
    output logic       duty_err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    // The counter saturates at 255, so very large ratios time out at 255.
    localparam int         TIMEOUT_INT = (2 * DIV_RATIO > 255) ? 255 : 2 * DIV_RATIO;
    localparam logic [7:0] DIV_VAL     = 8'(DIV_RATIO);
    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_INT);
    localparam logic [3:0] LOCK_VAL    = 4'(LOCK_CNT);

    state_t     state;
    state_t     state_nxt;
    logic       s1;
    logic       s2;
    logic       s3;
    logic       rise;
    logic [7:0] cnt;
    logic [3:0] good_cnt;
    logic [3:0] good_nxt;
    logic       err_evt;
    logic       period_ld;
    logic       duty_bad;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= clk_div_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

`ifdef CLK_DIV_MON_DUTY_CHECK_EN
    localparam logic [7:0] HALF_VAL = 8'(DIV_RATIO / 2);

    logic       fall;
    logic [7:0] high_cnt;

    assign fall     = ~s2 & s3;
    assign duty_bad = fall && (high_cnt != HALF_VAL);

    // high_cnt equals the number of cycles s2 was high when the fall is seen
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            high_cnt <= 8'd0;
        end else if (state == IDLE) begin
            high_cnt <= 8'd0;
        end else if (rise) begin
            high_cnt <= 8'd1;
        end else if (s2 && (high_cnt != 8'hFF)) begin
            high_cnt <= high_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            duty_err_o <= 1'b0;
        end else if (en && duty_bad && ((state == MEASURE) || (state == LOCKED))) begin
            duty_err_o <= 1'b1;
        end
    end
`else
    assign duty_bad   = 1'b0;
    assign duty_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (state == IDLE) begin
            cnt <= 8'd0;
        end else if (rise) begin
            cnt <= 8'd1;
        end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            good_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    // A rise is evaluated before the duty and timeout checks, so it wins on a tie.
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        err_evt   = 1'b0;
        period_ld = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            good_nxt  = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    good_nxt  = 4'd0;
                    state_nxt = ACQUIRE;
                end
                ACQUIRE: begin
                    if (rise) begin
                        good_nxt  = 4'd0;
                        state_nxt = MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    if (rise) begin
                        period_ld = 1'b1;
                        if (cnt == DIV_VAL) begin
                            if (state == MEASURE) begin
                                good_nxt = good_cnt + 4'd1;
                                if (good_nxt >= LOCK_VAL) begin
                                    state_nxt = LOCKED;
                                end
                            end
                        end else begin
                            err_evt   = 1'b1;
                            good_nxt  = 4'd0;
                            state_nxt = MEASURE;
                        end
                    end else if (duty_bad) begin
                        err_evt   = 1'b1;
                        good_nxt  = 4'd0;
                        state_nxt = MEASURE;
                    end else if (cnt == TIMEOUT_VAL) begin
                        err_evt   = 1'b1;
                        good_nxt  = 4'd0;
                        state_nxt = ACQUIRE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    good_nxt  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            period_o <= 8'd0;
        end else if (period_ld) begin
            period_o <= cnt;
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            err_cnt_o <= 8'd0;
        end else if (err_evt && (err_cnt_o != 8'hFF)) begin
            err_cnt_o <= err_cnt_o + 8'd1;
        end
    end

    assign err_o  = err_evt;
    assign lock_o = (state == LOCKED);

endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 The block SHALL have parameter DIV_RATIO, default 4, meaning the expected clk_div_i period in clk_i cycles (even, 2..254).
REQ-002 The block SHALL have parameter LOCK_CNT, default 4, meaning the number of consecutive correct periods required to assert lock (1..15).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all flops on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: monitor enable; low forces the IDLE state.
REQ-006 The block SHALL have port clk_div_i, input, 1 bit: the locally divided clock under test, treated as data.
REQ-007 The block SHALL have port lock_o, output, 1 bit: high while in the LOCKED state.
REQ-008 The block SHALL have port err_o, output, 1 bit: one-cycle pulse per detected period, timeout or duty error.
REQ-009 The block SHALL have port period_o, output, 8 bits: the last measured period in clk_i cycles.
REQ-010 The block SHALL have port err_cnt_o, output, 8 bits: saturating error count.
REQ-011 The block SHALL have port duty_err_o, output, 1 bit: sticky duty-cycle error flag.

Function
REQ-012 The block SHALL sample clk_div_i through a two-flop synchronizer (s1, s2) followed by a delay flop s3.
REQ-013 The block SHALL generate rise = s2 & ~s3 and fall = ~s2 & s3.
REQ-014 An input rising transition sampled at clk_i edge k SHALL produce rise high during the cycle after edge k+1.
REQ-015 The block SHALL implement an 8-bit period counter that resets to 1 on rise, otherwise increments, and saturates at 255.
REQ-016 The block SHALL implement a 4-bit good-period counter, good_cnt.
REQ-017 The state machine SHALL have exactly four states: IDLE, ACQUIRE, MEASURE and LOCKED.
REQ-018 IDLE SHALL go to ACQUIRE when en=1, and SHALL otherwise hold with counters cleared.
REQ-019 ACQUIRE SHALL go to MEASURE on the first rise, with good_cnt=0; no period is checked in ACQUIRE.
REQ-020 In MEASURE, on rise with counter==DIV_RATIO, the block SHALL increment good_cnt and go to LOCKED when good_cnt reaches LOCK_CNT.
REQ-021 In MEASURE, on rise with counter!=DIV_RATIO, the block SHALL pulse err_o, clear good_cnt and stay in MEASURE.
REQ-022 In LOCKED, on rise with counter!=DIV_RATIO, the block SHALL pulse err_o, drop lock_o on the next edge and go to MEASURE with good_cnt=0.
REQ-023 In MEASURE or LOCKED, when the counter reaches 2*DIV_RATIO without a rise, the block SHALL pulse err_o once and go to ACQUIRE.
REQ-024 period_o SHALL load the counter value on every rise in MEASURE or LOCKED, and SHALL otherwise hold.
REQ-025 err_cnt_o SHALL increment on each err_o pulse and saturate at 255; it SHALL be cleared only by rst.
REQ-026 Deassertion of en in any state SHALL go to IDLE on the next edge, clear lock_o, and emit no err_o pulse.
REQ-027 If a rise and the timeout coincide in the same cycle, the rise SHALL take priority.

Reset
REQ-028 On rst=1 the block SHALL immediately clear s1, s2, s3, all counters, period_o, err_cnt_o, err_o, lock_o and duty_err_o, and enter IDLE.
REQ-029 After rst deasserts, the first valid period check SHALL occur no earlier than the second detected rise.

Configuration
REQ-030 With macro CLK_DIV_MON_DUTY_CHECK_EN defined, the block SHALL measure high time (rise to fall, in clk_i cycles).
REQ-031 With CLK_DIV_MON_DUTY_CHECK_EN defined and in MEASURE or LOCKED, a fall with high time != DIV_RATIO/2 SHALL pulse err_o, set duty_err_o (sticky until rst) and follow the period-error transitions.
REQ-032 With CLK_DIV_MON_DUTY_CHECK_EN undefined, the block SHALL contain no high-time logic, tie duty_err_o to 0, and check period only.

Verification
REQ-033 The bench SHALL cover: rst pulse, en=1, clk_div_i toggling every 2 clk_i cycles -> lock_o=1 after the 5th rise (1 acquire + 4 good), period_o=4, err_cnt_o=0.
REQ-034 The bench SHALL cover: in LOCKED, one period stretched to 6 cycles -> single err_o pulse, lock_o=0, err_cnt_o=1, relock after 4 further good periods.
REQ-035 The bench SHALL cover: in LOCKED, clk_div_i held low -> err_o pulse 8 cycles after the last rise, state ACQUIRE, lock_o=0.
REQ-036 The bench SHALL cover: en dropped while LOCKED -> IDLE on the next edge, lock_o=0, no err_o, err_cnt_o unchanged.
REQ-037 The bench SHALL cover: with CLK_DIV_MON_DUTY_CHECK_EN, period 4 with high time 3 -> err_o pulse, duty_err_o=1; without the macro, the same stimulus -> no error and lock kept.
REQ-038 The bench SHALL cover: 300 forced errors -> err_cnt_o saturates at 255; rst asserted mid-period -> all outputs 0 asynchronously.
